// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RAM2 arbiter state encoding, the IF/ID NOP opcode
// and default bus widths.
package cpu_pkg;

   localparam int ADDR_W_DEF = 18;
   localparam int DATA_W_DEF = 16;

   localparam logic [15:0] NOP_INSTR = 16'h0800;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DREAD  = 3'd1;
   localparam logic [2:0] ST_WSETUP = 3'd2;
   localparam logic [2:0] ST_WPULSE = 3'd3;
   localparam logic [2:0] ST_WHOLD  = 3'd4;

   typedef enum logic [2:0] {
      FETCH  = ST_FETCH,
      DREAD  = ST_DREAD,
      WSETUP = ST_WSETUP,
      WPULSE = ST_WPULSE,
      WHOLD  = ST_WHOLD
   } arb_state_e;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter with enable that sticks at 0xFFFF instead of wrapping.
module sat_counter16 (
   input  logic        pci_clk,
   input  logic        pci_rst,
   input  logic        en,
   output logic [15:0] count
);

   logic [15:0] count_q;
   logic [15:0] count_d;

   always_comb begin
      count_d = count_q;
      if (en && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge pci_clk or negedge pci_rst) begin
      if (!pci_rst) begin
         count_q <= 16'h0000;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ram2_arbiter.sv
// RAM2 port sequencer: instruction fetch by default, data accesses from MEM
// take the port, freeze the PC and bubble IF/ID for a fixed-length sequence.
module ram2_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              pci_clk,
   input  logic              pci_rst,
   input  logic [15:0]       if_addr,
   output logic [DATA_W-1:0] if_instr,
   output logic              pc_en,
   output logic              ifid_bubble,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [15:0]       mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_done,
   output logic [ADDR_W-1:0] ram2_addr,
   input  logic [DATA_W-1:0] ram2_din,
   output logic [DATA_W-1:0] ram2_dout,
   output logic              ram2_drive,
   output logic              ram2_en_n,
   output logic              ram2_oe_n,
   output logic              ram2_we_n,
   output logic [15:0]       stall_cnt
);

   arb_state_e        state_q, state_d;
   logic [15:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              accept;

   // Gated by reset so the PC stays enabled while the block is held in reset.
   assign accept = (state_q == FETCH) && mem_req && pci_rst;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         FETCH: begin
            if (mem_req) begin
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
               state_d = mem_we ? WSETUP : DREAD;
            end
         end
         DREAD: begin
            rdata_d = ram2_din;
            state_d = FETCH;
         end
         WSETUP:  state_d = WPULSE;
         WPULSE:  state_d = WHOLD;
         WHOLD:   state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge pci_clk or negedge pci_rst) begin
      if (!pci_rst) begin
         state_q <= FETCH;
         addr_q  <= 16'h0000;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes and done come from state_q alone so input changes cannot glitch them.
   always_comb begin
      ram2_addr  = ADDR_W'(if_addr);
      ram2_en_n  = 1'b0;
      ram2_oe_n  = 1'b0;
      ram2_we_n  = 1'b1;
      ram2_drive = 1'b0;
      mem_done   = 1'b0;
      mem_rdata  = rdata_q;
      case (state_q)
         DREAD: begin
            ram2_addr = ADDR_W'(addr_q);
            mem_rdata = ram2_din;
            mem_done  = 1'b1;
         end
         WSETUP: begin
            ram2_addr  = ADDR_W'(addr_q);
            ram2_oe_n  = 1'b1;
            ram2_drive = 1'b1;
         end
         WPULSE: begin
            ram2_addr  = ADDR_W'(addr_q);
            ram2_oe_n  = 1'b1;
            ram2_we_n  = 1'b0;
            ram2_drive = 1'b1;
         end
         WHOLD: begin
            ram2_addr  = ADDR_W'(addr_q);
            ram2_oe_n  = 1'b1;
            ram2_drive = 1'b1;
            mem_done   = 1'b1;
         end
         default: ;
      endcase
   end

   assign pc_en       = (state_q == FETCH) && !accept;
   assign ifid_bubble = !pc_en;
   assign if_instr    = ram2_din;
   assign ram2_dout   = wdata_q;

   sat_counter16 u_stall_cnt (
      .pci_clk (pci_clk),
      .pci_rst (pci_rst),
      .en      (!pc_en),
      .count   (stall_cnt)
   );

endmodule

// File: tb/tb_ram2_arbiter.sv
// Directed bench for ram2_arbiter: stimulus pushes expected completions into a
// queue that a negedge monitor pops whenever mem_done is seen.
module tb_ram2_arbiter;
   import cpu_pkg::*;

   logic        pci_clk = 1'b0;
   logic        pci_rst;
   logic [15:0] if_addr;
   logic [15:0] if_instr;
   logic        pc_en;
   logic        ifid_bubble;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_done;
   logic [17:0] ram2_addr;
   logic [15:0] ram2_din;
   logic [15:0] ram2_dout;
   logic        ram2_drive;
   logic        ram2_en_n;
   logic        ram2_oe_n;
   logic        ram2_we_n;
   logic [15:0] stall_cnt;

   logic [15:0] pc;
   logic [15:0] pc0;

   typedef struct {
      bit          isRead;
      logic [15:0] data;
   } expT;

   expT expQ[$];
   int  total = 0;
   int  bad   = 0;

   ram2_arbiter #(.ADDR_W(18), .DATA_W(16)) dut (
      .pci_clk     (pci_clk),
      .pci_rst     (pci_rst),
      .if_addr     (if_addr),
      .if_instr    (if_instr),
      .pc_en       (pc_en),
      .ifid_bubble (ifid_bubble),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_done    (mem_done),
      .ram2_addr   (ram2_addr),
      .ram2_din    (ram2_din),
      .ram2_dout   (ram2_dout),
      .ram2_drive  (ram2_drive),
      .ram2_en_n   (ram2_en_n),
      .ram2_oe_n   (ram2_oe_n),
      .ram2_we_n   (ram2_we_n),
      .stall_cnt   (stall_cnt)
   );

   always #5 pci_clk = ~pci_clk;

   // Simple PC model: reset to 0x0005, advances whenever enabled.
   always @(posedge pci_clk or negedge pci_rst) begin
      if (!pci_rst) begin
         pc <= 16'h0005;
      end else if (pc_en) begin
         pc <= pc + 16'd1;
      end
   end
   assign if_addr = pc;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] din);
      mem_req   = req;
      mem_we    = we;
      mem_addr  = addr;
      mem_wdata = wdata;
      ram2_din  = din;
   endtask

   task automatic nextCycle();
      @(posedge pci_clk);
      #1;
   endtask

   // Monitor: every completion must match the oldest queued expectation.
   always @(negedge pci_clk) begin
      if (mem_done === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_mem_done", 32'd1, 32'd0);
         end else begin
            expT e;
            e = expQ.pop_front();
            if (e.isRead) begin
               checkOutput("sb_rdata", 32'(mem_rdata), 32'(e.data));
            end else begin
               checkOutput("sb_wdata", 32'(ram2_dout), 32'(e.data));
               checkOutput("sb_whold_strobes", {30'd0, ram2_drive, ram2_we_n}, 32'd3);
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      pci_rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h6801);
      #1;
      checkOutput("rst_pc_en", 32'(pc_en), 32'd1);
      checkOutput("rst_bubble", 32'(ifid_bubble), 32'd0);
      checkOutput("rst_mem_done", 32'(mem_done), 32'd0);
      checkOutput("rst_strobes", {28'd0, ram2_drive, ram2_we_n, ram2_oe_n, ram2_en_n}, 32'b0100);
      checkOutput("rst_rdata", 32'(mem_rdata), 32'h0);
      checkOutput("rst_stall", 32'(stall_cnt), 32'h0);
      repeat (2) nextCycle();
      pci_rst = 1'b1;

      // Idle fetch right after reset release
      @(negedge pci_clk);
      checkOutput("fetch_if_addr", 32'(if_addr), 32'h0005);
      checkOutput("fetch_instr", 32'(if_instr), 32'h6801);
      checkOutput("fetch_ram2_addr", 32'(ram2_addr), 32'h00005);
      checkOutput("fetch_pc_en", 32'(pc_en), 32'd1);
      checkOutput("fetch_oe_we", {30'd0, ram2_oe_n, ram2_we_n}, 32'b01);
      checkOutput("fetch_stall", 32'(stall_cnt), 32'h0);

      // Data read
      nextCycle();
      pc0 = pc;
      applyStimulus(1'b1, 1'b0, 16'h4010, 16'h0000, 16'h6801);
      expQ.push_back('{isRead: 1'b1, data: 16'hBEEF});
      @(negedge pci_clk);
      checkOutput("rd_c1_pc_en", 32'(pc_en), 32'd0);
      checkOutput("rd_c1_bubble", 32'(ifid_bubble), 32'd1);
      checkOutput("rd_c1_done", 32'(mem_done), 32'd0);
      nextCycle();
      ram2_din = 16'hBEEF;
      @(negedge pci_clk);
      checkOutput("rd_c2_addr", 32'(ram2_addr), 32'h04010);
      checkOutput("rd_c2_pc_en", 32'(pc_en), 32'd0);
      checkOutput("rd_c2_oe", 32'(ram2_oe_n), 32'd0);
      checkOutput("rd_c2_done", 32'(mem_done), 32'd1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1111);
      @(negedge pci_clk);
      checkOutput("rd_after_done", 32'(mem_done), 32'd0);
      checkOutput("rd_after_pc_en", 32'(pc_en), 32'd1);
      checkOutput("rd_rdata_held", 32'(mem_rdata), 32'hBEEF);
      checkOutput("rd_stall", 32'(stall_cnt), 32'd2);
      checkOutput("rd_pc_frozen", 32'(pc), 32'(pc0));

      // Data write
      nextCycle();
      pc0 = pc;
      applyStimulus(1'b1, 1'b1, 16'h4020, 16'h1234, 16'h6801);
      expQ.push_back('{isRead: 1'b0, data: 16'h1234});
      @(negedge pci_clk);
      checkOutput("wr_c1_pc_en", 32'(pc_en), 32'd0);
      checkOutput("wr_c1_we_drive", {30'd0, ram2_drive, ram2_we_n}, 32'b01);
      for (int c = 2; c <= 4; c++) begin
         nextCycle();
         @(negedge pci_clk);
         checkOutput($sformatf("wr_c%0d_we_n", c), 32'(ram2_we_n), (c == 3) ? 32'd0 : 32'd1);
         checkOutput($sformatf("wr_c%0d_drive", c), 32'(ram2_drive), 32'd1);
         checkOutput($sformatf("wr_c%0d_dout", c), 32'(ram2_dout), 32'h1234);
         checkOutput($sformatf("wr_c%0d_addr", c), 32'(ram2_addr), 32'h04020);
         checkOutput($sformatf("wr_c%0d_oe", c), 32'(ram2_oe_n), 32'd1);
         checkOutput($sformatf("wr_c%0d_pc_en", c), 32'(pc_en), 32'd0);
         checkOutput($sformatf("wr_c%0d_done", c), 32'(mem_done), (c == 4) ? 32'd1 : 32'd0);
      end
      nextCycle();
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h6801);
      @(negedge pci_clk);
      checkOutput("wr_after_pc_en", 32'(pc_en), 32'd1);
      checkOutput("wr_after_drive", 32'(ram2_drive), 32'd0);
      checkOutput("wr_stall", 32'(stall_cnt), 32'd6);
      checkOutput("wr_pc_frozen", 32'(pc), 32'(pc0));

      // Back-to-back: read then write requested in the cycle after mem_done
      nextCycle();
      pc0 = pc;
      applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h5A5A);
      expQ.push_back('{isRead: 1'b1, data: 16'h5A5A});
      expQ.push_back('{isRead: 1'b0, data: 16'hCAFE});
      for (int c = 1; c <= 6; c++) begin
         @(negedge pci_clk);
         checkOutput($sformatf("b2b_c%0d_pc_en", c), 32'(pc_en), 32'd0);
         nextCycle();
         if (c == 2) begin
            applyStimulus(1'b1, 1'b1, 16'h0200, 16'hCAFE, 16'h6801);
         end
      end
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h6801);
      @(negedge pci_clk);
      checkOutput("b2b_after_pc_en", 32'(pc_en), 32'd1);
      checkOutput("b2b_stall", 32'(stall_cnt), 32'd12);
      checkOutput("b2b_pc_frozen", 32'(pc), 32'(pc0));
      checkOutput("b2b_rdata_held", 32'(mem_rdata), 32'h5A5A);

      // Reset asserted during WPULSE
      nextCycle();
      applyStimulus(1'b1, 1'b1, 16'h0300, 16'h9999, 16'h6801);
      repeat (2) nextCycle();
      @(negedge pci_clk);
      checkOutput("rstw_pulse_we_n", 32'(ram2_we_n), 32'd0);
      #1;
      pci_rst = 1'b0;
      #1;
      checkOutput("rstw_we_n", 32'(ram2_we_n), 32'd1);
      checkOutput("rstw_drive", 32'(ram2_drive), 32'd0);
      checkOutput("rstw_pc_en", 32'(pc_en), 32'd1);
      checkOutput("rstw_done", 32'(mem_done), 32'd0);
      mem_req = 1'b0;
      nextCycle();
      pci_rst = 1'b1;
      @(negedge pci_clk);
      checkOutput("rstw_post_strobes", {28'd0, ram2_drive, ram2_we_n, ram2_oe_n, ram2_en_n}, 32'b0100);
      checkOutput("rstw_post_pc_en", 32'(pc_en), 32'd1);
      checkOutput("rstw_post_rdata", 32'(mem_rdata), 32'h0);
      checkOutput("rstw_post_stall", 32'(stall_cnt), 32'h0);

      // Saturation: 70000 back-to-back write cycles, each completion queued
      nextCycle();
      for (int i = 0; i < 17500; i++) begin
         expQ.push_back('{isRead: 1'b0, data: 16'h00A5});
      end
      applyStimulus(1'b1, 1'b1, 16'h0400, 16'h00A5, 16'h6801);
      repeat (70000) @(posedge pci_clk);
      #1;
      mem_req = 1'b0;
      @(negedge pci_clk);
      checkOutput("sat_value", 32'(stall_cnt), 32'hFFFF);
      checkOutput("sat_pc_en", 32'(pc_en), 32'd1);

      nextCycle();
      applyStimulus(1'b1, 1'b0, 16'h0500, 16'h0000, 16'h7777);
      expQ.push_back('{isRead: 1'b1, data: 16'h7777});
      repeat (2) nextCycle();
      mem_req = 1'b0;
      @(negedge pci_clk);
      checkOutput("sat_stays", 32'(stall_cnt), 32'hFFFF);

      repeat (2) nextCycle();
      checkOutput("sb_queue_empty", 32'(expQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
